// File: rtl/serial_magnitude_comparator.sv
// Bit-serial MSB-first magnitude comparator, signed or unsigned per operation.
// Latency: 1..WIDTH cycles after start; stops at the first differing bit.
// Backpressure: none. start is ignored while busy, and the result holds in DONE until the next start.
// Ports: clk/res (async active-high) | start, sgn, a, b in | busy, done, L, E, G, cycles out
module serial_magnitude_comparator #(
   parameter int WIDTH = 32,
   parameter int CW    = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             res,
   input  logic             start,
   input  logic             sgn,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             L,
   output logic             E,
   output logic             G,
   output logic [CW-1:0]    cycles
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic             sgn_q;
   logic [CW-1:0]    k;       // index of the bit pair being compared, counted from the MSB
   logic             ma;
   logic             mb;

   assign ma = sa[WIDTH-1];
   assign mb = sb[WIDTH-1];

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state  <= IDLE;
         sa     <= '0;
         sb     <= '0;
         sgn_q  <= 1'b0;
         k      <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         L      <= 1'b0;
         E      <= 1'b0;
         G      <= 1'b0;
         cycles <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  sa     <= a;
                  sb     <= b;
                  sgn_q  <= sgn;
                  k      <= '0;
                  L      <= 1'b0;
                  E      <= 1'b0;
                  G      <= 1'b0;
                  done   <= 1'b0;
                  cycles <= '0;
                  busy   <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               sa     <= {sa[WIDTH-2:0], 1'b0};
               sb     <= {sb[WIDTH-2:0], 1'b0};
               k      <= k + CW'(1);
               cycles <= cycles + CW'(1);
               if (ma != mb) begin
                  // In signed mode the first bit is the sign: a set bit marks the smaller operand.
                  if (k == '0 && sgn_q) begin
                     L <= ma;
                     G <= mb;
                  end else begin
                     G <= ma;
                     L <= mb;
                  end
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else if (k == LAST) begin
                  E     <= 1'b1;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Bench for serial_magnitude_comparator: directed WIDTH=32 scenarios, plus a random sweep on WIDTH=2/8/33.
// Latency: checks the exact cycle at which done rises, against hand-computed values.
// Backpressure: checks that start is ignored during RUN and exercises back-to-back starts from DONE.
module tb_serial_magnitude_comparator;

   logic        clk = 1'b0;
   logic        res = 1'b1;
   logic        start = 1'b0;
   logic        sgn = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        busy, done, L, E, G;
   logic [5:0]  cycles;

   // shared stimulus for the sweep instances
   logic        start_x = 1'b0;
   logic        sx = 1'b0;
   logic [63:0] ra = '0;
   logic [63:0] rb = '0;
   logic        bz2, d2, l2, e2, g2;
   logic        bz8, d8, l8, e8, g8;
   logic        bz33, d33, l33, e33, g33;
   logic [1:0]  cy2;
   logic [3:0]  cy8;
   logic [6:0]  cy33;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   serial_magnitude_comparator #(.WIDTH(32)) dut (
      .clk(clk), .res(res), .start(start), .sgn(sgn), .a(a), .b(b),
      .busy(busy), .done(done), .L(L), .E(E), .G(G), .cycles(cycles));

   serial_magnitude_comparator #(.WIDTH(2)) dut2 (
      .clk(clk), .res(res), .start(start_x), .sgn(sx), .a(ra[1:0]), .b(rb[1:0]),
      .busy(bz2), .done(d2), .L(l2), .E(e2), .G(g2), .cycles(cy2));

   serial_magnitude_comparator #(.WIDTH(8)) dut8 (
      .clk(clk), .res(res), .start(start_x), .sgn(sx), .a(ra[7:0]), .b(rb[7:0]),
      .busy(bz8), .done(d8), .L(l8), .E(e8), .G(g8), .cycles(cy8));

   serial_magnitude_comparator #(.WIDTH(33)) dut33 (
      .clk(clk), .res(res), .start(start_x), .sgn(sx), .a(ra[32:0]), .b(rb[32:0]),
      .busy(bz33), .done(d33), .L(l33), .E(e33), .G(g33), .cycles(cy33));

   // Reference: native (signed) compare on sign-extended values; n counts the bits up to and including the first difference.
   function automatic void ref_cmp(input logic [63:0] xa, input logic [63:0] xb, input logic s,
                                   input int w, output logic [2:0] leg, output int n);
      logic [63:0] mask;
      logic [63:0] ax;
      logic [63:0] bx;
      logic        lt;
      mask = (64'd1 << w) - 64'd1;
      ax = xa & mask;
      bx = xb & mask;
      if (s) begin
         if (ax[w-1]) ax = ax | ~mask;
         if (bx[w-1]) bx = bx | ~mask;
         lt = $signed(ax) < $signed(bx);
      end else begin
         lt = ax < bx;
      end
      n = w;
      for (int i = w - 1; i >= 0; i--) begin
         if (ax[i] != bx[i]) begin
            n = w - i;
            break;
         end
      end
      leg = (ax == bx) ? 3'b010 : (lt ? 3'b100 : 3'b001);
   endfunction

   // Launch one operation on the WIDTH=32 instance. lat = edges from acceptance to done; bc = cycles seen busy.
   task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic s,
                         output int lat, output int bc);
      a = ia;
      b = ib;
      sgn = s;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      bc = 0;
      while (!done && lat < 40) begin
         if (busy) bc++;
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset();
      int lat, bc;
      res = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, L, E, G, cycles} !== 11'b0) begin
         failures++;
         $display("FAIL reset_state got=%b want=0", {busy, done, L, E, G, cycles});
      end
      res = 1'b0;
      a = 32'd5; b = 32'd7; sgn = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #3;
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL busy_before_abort got=%b want=1", busy);
      end
      res = 1'b1;
      #1;
      checks++;
      if ({busy, done, L, E, G, cycles} !== 11'b0) begin
         failures++;
         $display("FAIL async_abort got=%b want=0", {busy, done, L, E, G, cycles});
      end
      #1;
      res = 1'b0;
      run_op(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, lat, bc);
      checks++;
      if ({L, E, G} !== 3'b100 || cycles !== 6'd1 || lat != 1) begin
         failures++;
         $display("FAIL after_abort leg=%b cycles=%0d lat=%0d want leg=100 cycles=1 lat=1", {L, E, G}, cycles, lat);
      end
   endtask

   task automatic test_msb();
      int lat, bc;
      run_op(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, lat, bc);
      checks++;
      if ({L, E, G} !== 3'b001 || cycles !== 6'd1 || lat != 1) begin
         failures++;
         $display("FAIL msb_unsigned leg=%b cycles=%0d lat=%0d want leg=001 cycles=1 lat=1", {L, E, G}, cycles, lat);
      end
      // outputs must hold in DONE while inputs wander and start stays low
      a = 32'h0; b = 32'hFFFF_FFFF; sgn = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({done, L, E, G} !== 4'b1001 || cycles !== 6'd1) begin
         failures++;
         $display("FAIL done_hold dleg=%b cycles=%0d want dleg=1001 cycles=1", {done, L, E, G}, cycles);
      end
      run_op(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, lat, bc);
      checks++;
      if ({L, E, G} !== 3'b100 || cycles !== 6'd1 || lat != 1) begin
         failures++;
         $display("FAIL msb_signed leg=%b cycles=%0d lat=%0d want leg=100 cycles=1 lat=1", {L, E, G}, cycles, lat);
      end
   endtask

   task automatic test_equal();
      int lat, bc;
      run_op(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, lat, bc);
      checks++;
      if ({L, E, G} !== 3'b010 || cycles !== 6'd32 || lat != 32 || bc != 32) begin
         failures++;
         $display("FAIL equal leg=%b cycles=%0d lat=%0d busy=%0d want leg=010 cycles=32 lat=32 busy=32",
                  {L, E, G}, cycles, lat, bc);
      end
   endtask

   task automatic test_lsb();
      int lat, bc;
      run_op(32'd5, 32'd7, 1'b0, lat, bc);
      checks++;
      if ({L, E, G} !== 3'b100 || cycles !== 6'd31 || lat != 31) begin
         failures++;
         $display("FAIL five_vs_seven leg=%b cycles=%0d lat=%0d want leg=100 cycles=31 lat=31", {L, E, G}, cycles, lat);
      end
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, lat, bc);
      checks++;
      if ({L, E, G} !== 3'b001 || cycles !== 6'd32 || lat != 32) begin
         failures++;
         $display("FAIL m1_vs_m2 leg=%b cycles=%0d lat=%0d want leg=001 cycles=32 lat=32", {L, E, G}, cycles, lat);
      end
   endtask

   task automatic test_back_to_back();
      int e;
      a = 32'd5; b = 32'd7; sgn = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      e = 0;
      repeat (2) begin @(posedge clk); #1; e++; end
      // start pulses at edges 3 and 5 with different operands must be ignored
      a = 32'd7; b = 32'd5; sgn = 1'b1; start = 1'b1;
      @(posedge clk); #1; e++;
      start = 1'b0;
      @(posedge clk); #1; e++;
      start = 1'b1;
      @(posedge clk); #1; e++;
      start = 1'b0;
      while (!done && e < 40) begin @(posedge clk); #1; e++; end
      checks++;
      if ({L, E, G} !== 3'b100 || cycles !== 6'd31 || e != 31) begin
         failures++;
         $display("FAIL ignore_start leg=%b cycles=%0d lat=%0d want leg=100 cycles=31 lat=31", {L, E, G}, cycles, e);
      end
      // start held high in DONE relaunches at the next edge
      a = 32'h0000_0000; b = 32'h8000_0000; sgn = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b1 || {L, E, G} !== 3'b000) begin
         failures++;
         $display("FAIL b2b_gap done=%b busy=%b leg=%b want done=0 busy=1 leg=000", done, busy, {L, E, G});
      end
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if ({done, L, E, G} !== 4'b1001 || cycles !== 6'd1) begin
         failures++;
         $display("FAIL b2b_result dleg=%b cycles=%0d want dleg=1001 cycles=1", {done, L, E, G}, cycles);
      end
   endtask

   task automatic test_sweep();
      logic [2:0] leg;
      int n, t;
      for (int i = 0; i < 1000; i++) begin
         ra = {$urandom(), $urandom()};
         rb = {$urandom(), $urandom()};
         case ($urandom_range(0, 3))
            0: rb = ra;
            1: rb = ra ^ (64'd1 << $urandom_range(0, 32));
            default: ;
         endcase
         sx = 1'($urandom_range(0, 1));
         start_x = 1'b1;
         @(posedge clk); #1;
         start_x = 1'b0;
         t = 0;
         while (!(d2 && d8 && d33) && t < 40) begin @(posedge clk); #1; t++; end
         ref_cmp(ra, rb, sx, 2, leg, n);
         checks++;
         if ({d2, l2, e2, g2} !== {1'b1, leg} || int'(cy2) != n) begin
            failures++;
            $display("FAIL sweep_w2 a=%h b=%h s=%b dleg=%b cyc=%0d want leg=%b cyc=%0d", ra[1:0], rb[1:0], sx, {d2, l2, e2, g2}, cy2, leg, n);
         end
         ref_cmp(ra, rb, sx, 8, leg, n);
         checks++;
         if ({d8, l8, e8, g8} !== {1'b1, leg} || int'(cy8) != n) begin
            failures++;
            $display("FAIL sweep_w8 a=%h b=%h s=%b dleg=%b cyc=%0d want leg=%b cyc=%0d", ra[7:0], rb[7:0], sx, {d8, l8, e8, g8}, cy8, leg, n);
         end
         ref_cmp(ra, rb, sx, 33, leg, n);
         checks++;
         if ({d33, l33, e33, g33} !== {1'b1, leg} || int'(cy33) != n) begin
            failures++;
            $display("FAIL sweep_w33 a=%h b=%h s=%b dleg=%b cyc=%0d want leg=%b cyc=%0d", ra[32:0], rb[32:0], sx, {d33, l33, e33, g33}, cy33, leg, n);
         end
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_msb();
      test_equal();
      test_lsb();
      test_back_to_back();
      test_sweep();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_magnitude_comparator.md
# serial_magnitude_comparator

Parametrised bit-serial magnitude comparator: captures two WIDTH-bit operands on a start request and compares them MSB-first, one bit per clock, with early termination at the first differing bit. It supports per-operation signed (two's complement) or unsigned mode and reports less/equal/greater with a done/busy handshake and a cycle count. It is the generalised successor to the fixed 32-bit unsigned serial comparator and is used wherever a compact, area-cheap compare unit is needed in the datapath.

## Interface
- WIDTH, 32, operand width in bits; legal range WIDTH >= 2.
- CW, $clog2(WIDTH)+1, width of the cycle-count output (derived; not overridden).

- clk  input  1  single clock; all state updates on rising edge.
- res  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted on a rising edge when state is IDLE or DONE.
- sgn  input  1  mode, sampled with start: 1 = signed two's complement, 0 = unsigned.
- a  input  WIDTH  operand A, sampled with start.
- b  input  WIDTH  operand B, sampled with start.
- busy  output  1  high while a comparison is in progress (state RUN).
- done  output  1  high while a valid result is held (state DONE).
- L  output  1  A < B; valid only while done = 1.
- E  output  1  A == B; valid only while done = 1.
- G  output  1  A > B; valid only while done = 1.
- cycles  output  CW  number of bit-compare cycles used by the last operation; valid while done = 1.

## Operation
- States: IDLE, RUN, DONE.
- Reset (res = 1, asynchronous): state goes to IDLE; busy, done, L, E, G = 0; cycles = 0; internal shift registers and the bit counter are cleared.
- IDLE/DONE + start = 1: at the rising edge, a and b load into left-shift registers, sgn is latched, the bit counter is set to 0, L/E/G/done/cycles clear to 0, and the state goes to RUN.
- DONE + start = 0: hold all outputs.
- RUN: each edge compares the current MSBs of both shift registers (bit index WIDTH-1-k on cycle k), increments cycles, and shifts both registers left by one.
  - Bits differ on cycle k = 0 (sign position) with sgn = 1: the operand whose bit is 1 is smaller (a bit = 1 gives L, otherwise G).
  - Bits differ in any other case: the operand whose bit is 1 is larger (a bit = 1 gives G, otherwise L).
  - On any difference, the state goes to DONE.
  - Bits equal on k = WIDTH-1: E = 1 and the state goes to DONE.
  - Bits equal otherwise: stay in RUN.
- start during RUN is ignored; operands and mode are not re-sampled.
- Exactly one of L/E/G is 1 in DONE; all three are 0 in IDLE and RUN.
- Changes on a, b or sgn outside the start edge have no effect.

## Timing
- Let n = 1 + (number of leading equal bits), capped at WIDTH.
- Start is accepted at edge 0. busy = 1 from edge 0 until edge n. done, L/E/G and cycles = n are valid from edge n.
- Minimum latency is 1 cycle (MSBs differ). Maximum latency is WIDTH cycles (equal operands, or a difference only in bit 0).
- Back-to-back operation: start held high in DONE launches the next compare at the next edge; done drops for at least one cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- res asserted mid-RUN aborts immediately to IDLE with all outputs 0. The first start after res deasserts behaves as from reset.

## Test plan
- Reset: pulse res asynchronously between clock edges -> busy = done = L = E = G = 0 and cycles = 0 immediately. Assert res mid-RUN -> same, and a following start compares correctly.
- WIDTH = 32, a = 0x80000000, b = 0x7FFFFFFF: with sgn = 0 -> G = 1, cycles = 1, done at edge 1. With sgn = 1 -> L = 1, cycles = 1.
- WIDTH = 32, a = b = 0xDEADBEEF, sgn = 0 -> busy for 32 cycles, then E = 1 and cycles = 32.
- WIDTH = 32, a = 5, b = 7, sgn = 0 -> L = 1, cycles = 31, done at edge 31. With sgn = 1, a = 0xFFFFFFFF, b = 0xFFFFFFFE -> G = 1, cycles = 32.
- Handshake: pulse start again at edges 3 and 5 during a RUN with different operands -> ignored, and the original result is reported. Hold start high in DONE -> the next operation launches, done low for one cycle, and the new result is correct.
- Parameter sweep for WIDTH = 2, 8, 33: random a/b/sgn (1000 operations each) checked against the reference compare, including the cycles value.
